aes_key_expand: RTL

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_sbox.sv | 38 +++
 rtl/aes_key_expand.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: state encoding, Rcon table, block size
// and the legal (Nk, Nr) pairs.
package aes_pkg;

  localparam int NB = 4;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_256 = 4'd14;

  // Entry k holds Rcon[k+1]; Rcon[0] is never used.
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic is_legal(input logic [3:0] nk, input logic [3:0] nr);
    return (nk == NK_128 && nr == NR_128) ||
           (nk == NK_192 && nr == NR_192) ||
           (nk == NK_256 && nr == NR_256);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform, so no lookup ROM is needed.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the inverse for nonzero x and maps 0 to 0.
  always_comb begin : inv_affine
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = in_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key expansion, one round-key word per cycle.
// Define AES_KEYEXP_STALL_EN to add a ready_i back-pressure input.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
`ifdef AES_KEYEXP_STALL_EN
  input  logic         ready_i,
`endif
  input  logic [255:0] key_i,
  input  logic [3:0]   Nk_i,
  input  logic [3:0]   Nr_i,
  output logic [31:0]  w_o,
  output logic [5:0]   w_idx_o,
  output logic         w_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  state_t       state;
  logic [255:0] key_q;
  logic [3:0]   nk_q;
  logic [3:0]   nr_q;
  logic [2:0]   mod_cnt;
  logic [3:0]   rcon_idx;
  logic [31:0]  hist [8];
  logic [31:0]  key_word [8];
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [31:0]  next_word;
  logic [5:0]   next_idx;
  logic [5:0]   last_idx;
  logic [2:0]   nk_last;
  logic [7:0]   rcon;
  logic         advance;

`ifdef AES_KEYEXP_STALL_EN
  assign advance = w_valid_o && ready_i;
`else
  assign advance = w_valid_o;
`endif

  genvar g;
  for (g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  // mod_cnt and rcon_idx describe the word about to be produced (index next_idx).
  always_comb begin
    nk_last  = 3'(nk_q - 4'd1);
    next_idx = w_idx_o + 6'd1;
    last_idx = 6'(NB * (int'(nr_q) + 1) - 1);
    rcon     = (rcon_idx == 4'd0) ? 8'h00 : RCON[rcon_idx - 4'd1];
    sub_in   = (mod_cnt == 3'd0) ? {hist[0][23:0], hist[0][31:24]} : hist[0];
    temp     = hist[0];
    if (mod_cnt == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if (nk_q == NK_256 && mod_cnt == 3'd4) begin
      temp = sub_out;
    end
    for (int k = 0; k < 8; k++) begin
      key_word[k] = key_q[255 - 32*k -: 32];
    end
    next_word = (rcon_idx == 4'd0) ? key_word[next_idx[2:0]] : (hist[nk_last] ^ temp);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      key_q     <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      mod_cnt   <= '0;
      rcon_idx  <= '0;
      w_o       <= '0;
      w_idx_o   <= '0;
      w_valid_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (is_legal(Nk_i, Nr_i)) begin
              state     <= RUN;
              key_q     <= key_i;
              nk_q      <= Nk_i;
              nr_q      <= Nr_i;
              w_o       <= key_i[255:224];
              w_idx_o   <= 6'd0;
              w_valid_o <= 1'b1;
              busy_o    <= 1'b1;
              done_o    <= 1'b0;
              mod_cnt   <= 3'd1;
              rcon_idx  <= 4'd0;
              hist[0]   <= key_i[255:224];
              for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (advance) begin
            if (done_o) begin
              state     <= IDLE;
              w_valid_o <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b0;
            end else begin
              w_o     <= next_word;
              w_idx_o <= next_idx;
              done_o  <= (next_idx == last_idx);
              hist[0] <= next_word;
              for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
              if (mod_cnt == nk_last) begin
                mod_cnt  <= 3'd0;
                rcon_idx <= rcon_idx + 4'd1;
              end else begin
                mod_cnt <= mod_cnt + 3'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
